// File: rtl/src_shift_reg_out_pkg.sv
// ---------------------------------------------------------------------------
// src_shift_reg_out_pkg
// Shared ALU constants for the source-side wavefront collector: per-lane
// operand width, wavefront lane count, ALU beat width and the beat index
// type. A 64-lane wavefront is always issued as four 16-lane beats, in the
// same order the destination collector re-assembles them.
// ---------------------------------------------------------------------------
package src_shift_reg_out_pkg;

    localparam int DATA_W     = 32;
    localparam int LANES      = 64;
    localparam int BEAT_LANES = 16;
    localparam int BEATS      = LANES / BEAT_LANES;

    typedef logic [1:0] beat_idx_t;

    localparam beat_idx_t BEAT_FIRST = 2'd0;
    localparam beat_idx_t BEAT_LAST  = 2'd3;

    // Advance to the following beat; callers only use it below BEAT_LAST.
    function automatic beat_idx_t next_beat(input beat_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/src_shift_reg_out_shift_in_slice.sv
// ---------------------------------------------------------------------------
// shift_in_slice
// Stores one full wavefront worth of a single source field (LANES x W bits)
// and presents the BEAT_LANES x W bit group chosen by the beat index on a
// registered output.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-low
//   ld_en    in   capture data_in; output jumps to lanes 0..BEAT_LANES-1
//   adv_en   in   move output to the lane group selected by sel_idx
//   sel_idx  in   beat index the output should show after this edge
//   data_in  in   LANES x W packed field, lane i at [W*i +: W]
//   data_out out  BEAT_LANES x W packed field for the current beat
// ---------------------------------------------------------------------------
module shift_in_slice
    import src_shift_reg_out_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_en,
    input  logic                    adv_en,
    input  beat_idx_t               sel_idx,
    input  logic [LANES*W-1:0]      data_in,
    output logic [BEAT_LANES*W-1:0] data_out
);

    localparam int SLICE_W = BEAT_LANES * W;

    logic [LANES*W-1:0] store_r;
    logic [SLICE_W-1:0] out_r;
    logic [SLICE_W-1:0] sel_s;

    // 4:1 lane-group mux over the stored wavefront.
    always_comb begin
        sel_s = {SLICE_W{1'b0}};
        case (sel_idx)
            2'd0:    sel_s = store_r[1*SLICE_W-1:0*SLICE_W];
            2'd1:    sel_s = store_r[2*SLICE_W-1:1*SLICE_W];
            2'd2:    sel_s = store_r[3*SLICE_W-1:2*SLICE_W];
            2'd3:    sel_s = store_r[4*SLICE_W-1:3*SLICE_W];
            default: sel_s = store_r[1*SLICE_W-1:0*SLICE_W];
        endcase
    end

    // Wavefront storage and registered beat output. On load, beat 0 is taken
    // straight from data_in so it appears one cycle after the load edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            store_r <= {(LANES*W){1'b0}};
            out_r   <= {SLICE_W{1'b0}};
        end else if (ld_en) begin
            store_r <= data_in;
            out_r   <= data_in[SLICE_W-1:0];
        end else if (adv_en) begin
            store_r <= store_r;
            out_r   <= sel_s;
        end else begin
            store_r <= store_r;
            out_r   <= out_r;
        end
    end

    assign data_out = out_r;

endmodule

// File: rtl/src_shift_reg_out.sv
// ---------------------------------------------------------------------------
// src_shift_reg_out
// Source-side counterpart of the ALU destination collector. Captures a
// 64-lane operand set (A, B, exec, VCC) in one load and issues it to the
// 16-lane ALU as four beats, lanes 0-15 first. Beats are issued on a fixed
// cadence regardless of exec content. Output data holds its last value in
// IDLE; consumers qualify with beat_valid.
//
// Ports:
//   clk                  in   clock
//   rst                  in   synchronous reset, active-low
//   src_a_data           in   2048  operand A, lane i at [32i+31:32i]
//   src_b_data           in   2048  operand B, same packing
//   src_exec_value       in   64    exec mask, bit i = lane i
//   src_vcc_value        in   64    VCC, bit i = lane i
//   src_buffer_ld_en     in   capture all source inputs (wins over shift)
//   src_buffer_shift_en  in   consumer accepts the current beat
//   alu_src_a_data       out  512   operand A for the current beat
//   alu_src_b_data       out  512   operand B for the current beat
//   alu_exec_value       out  16    exec slice for the current beat
//   alu_vcc_value        out  16    VCC slice for the current beat
//   beat_valid           out  current beat is valid
//   beat_idx             out  current beat number 0..3
//   beat_last            out  beat_valid && beat_idx==3
//   busy                 out  beats pending (same as beat_valid)
// ---------------------------------------------------------------------------
module src_shift_reg_out
    import src_shift_reg_out_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES*DATA_W-1:0]      src_a_data,
    input  logic [LANES*DATA_W-1:0]      src_b_data,
    input  logic [LANES-1:0]             src_exec_value,
    input  logic [LANES-1:0]             src_vcc_value,
    input  logic                         src_buffer_ld_en,
    input  logic                         src_buffer_shift_en,
    output logic [BEAT_LANES*DATA_W-1:0] alu_src_a_data,
    output logic [BEAT_LANES*DATA_W-1:0] alu_src_b_data,
    output logic [BEAT_LANES-1:0]        alu_exec_value,
    output logic [BEAT_LANES-1:0]        alu_vcc_value,
    output logic                         beat_valid,
    output beat_idx_t                    beat_idx,
    output logic                         beat_last,
    output logic                         busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0] state_r;
    logic [0:0] state_s;
    beat_idx_t  idx_r;
    beat_idx_t  idx_s;
    logic       last_r;
    logic       last_s;
    logic       adv_s;

    // Beat sequencing: load restarts at beat 0 from any state; a shift on the
    // last beat returns to IDLE without moving the data outputs.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        adv_s   = 1'b0;
        if (src_buffer_ld_en) begin
            state_s = ST_ISSUE;
            idx_s   = BEAT_FIRST;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                    idx_s   = BEAT_FIRST;
                end
                ST_ISSUE: begin
                    if (src_buffer_shift_en) begin
                        if (idx_r == BEAT_LAST) begin
                            state_s = ST_IDLE;
                            idx_s   = BEAT_FIRST;
                        end else begin
                            state_s = ST_ISSUE;
                            idx_s   = next_beat(idx_r);
                            adv_s   = 1'b1;
                        end
                    end else begin
                        state_s = ST_ISSUE;
                        idx_s   = idx_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    idx_s   = BEAT_FIRST;
                end
            endcase
        end
        last_s = (state_s == ST_ISSUE) && (idx_s == BEAT_LAST);
    end

    // Beat counter / FSM registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            idx_r   <= BEAT_FIRST;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            last_r  <= last_s;
        end
    end

    shift_in_slice #(.W(DATA_W)) u_slice_a (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (src_buffer_ld_en),
        .adv_en   (adv_s),
        .sel_idx  (idx_s),
        .data_in  (src_a_data),
        .data_out (alu_src_a_data)
    );

    shift_in_slice #(.W(DATA_W)) u_slice_b (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (src_buffer_ld_en),
        .adv_en   (adv_s),
        .sel_idx  (idx_s),
        .data_in  (src_b_data),
        .data_out (alu_src_b_data)
    );

    shift_in_slice #(.W(1)) u_slice_exec (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (src_buffer_ld_en),
        .adv_en   (adv_s),
        .sel_idx  (idx_s),
        .data_in  (src_exec_value),
        .data_out (alu_exec_value)
    );

    shift_in_slice #(.W(1)) u_slice_vcc (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (src_buffer_ld_en),
        .adv_en   (adv_s),
        .sel_idx  (idx_s),
        .data_in  (src_vcc_value),
        .data_out (alu_vcc_value)
    );

    assign beat_valid = state_r;
    assign busy       = state_r;
    assign beat_idx   = idx_r;
    assign beat_last  = last_r;

endmodule

// File: tb/tb_src_shift_reg_out.sv
// ---------------------------------------------------------------------------
// tb_src_shift_reg_out
// Directed bench for src_shift_reg_out. Each wavefront uses A lane i =
// base_a+i and B lane i = base_b+i, so every beat's expected 16-lane group is
// rebuilt from the base; exec/VCC beat slices are written out by hand.
// ---------------------------------------------------------------------------
module tb_src_shift_reg_out;

    logic          clk;
    logic          rst;
    logic [2047:0] src_a_data;
    logic [2047:0] src_b_data;
    logic [63:0]   src_exec_value;
    logic [63:0]   src_vcc_value;
    logic          src_buffer_ld_en;
    logic          src_buffer_shift_en;
    logic [511:0]  alu_src_a_data;
    logic [511:0]  alu_src_b_data;
    logic [15:0]   alu_exec_value;
    logic [15:0]   alu_vcc_value;
    logic          beat_valid;
    logic [1:0]    beat_idx;
    logic          beat_last;
    logic          busy;

    int n_checks = 0;
    int n_fails  = 0;

    src_shift_reg_out dut (
        .clk                 (clk),
        .rst                 (rst),
        .src_a_data          (src_a_data),
        .src_b_data          (src_b_data),
        .src_exec_value      (src_exec_value),
        .src_vcc_value       (src_vcc_value),
        .src_buffer_ld_en    (src_buffer_ld_en),
        .src_buffer_shift_en (src_buffer_shift_en),
        .alu_src_a_data      (alu_src_a_data),
        .alu_src_b_data      (alu_src_b_data),
        .alu_exec_value      (alu_exec_value),
        .alu_vcc_value       (alu_vcc_value),
        .beat_valid          (beat_valid),
        .beat_idx            (beat_idx),
        .beat_last           (beat_last),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full wavefront with lane i = base + i.
    function automatic logic [2047:0] mk_vec(input logic [31:0] base);
        logic [2047:0] v;
        v = {2048{1'b0}};
        for (int i = 0; i < 64; i++) begin
            v[i*32 +: 32] = base + 32'(i);
        end
        return v;
    endfunction

    // Expected beat k of such a wavefront: lanes 16k..16k+15.
    function automatic logic [511:0] mk_slice(input logic [31:0] base, input int k);
        logic [511:0] s;
        s = {512{1'b0}};
        for (int j = 0; j < 16; j++) begin
            s[j*32 +: 32] = base + 32'(16*k + j);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic valid, input logic [1:0] idx, input logic last);
        check({tag, "_valid"}, 512'(beat_valid), 512'(valid));
        check({tag, "_busy"},  512'(busy),       512'(valid));
        check({tag, "_idx"},   512'(beat_idx),   512'(idx));
        check({tag, "_last"},  512'(beat_last),  512'(last));
    endtask

    task automatic check_beat(input string tag, input logic [31:0] base_a, input logic [31:0] base_b,
                              input int k, input logic [15:0] exp_exec, input logic [15:0] exp_vcc,
                              input logic valid, input logic [1:0] idx, input logic last);
        check({tag, "_a"},    alu_src_a_data,        mk_slice(base_a, k));
        check({tag, "_b"},    alu_src_b_data,        mk_slice(base_b, k));
        check({tag, "_exec"}, 512'(alu_exec_value),  512'(exp_exec));
        check({tag, "_vcc"},  512'(alu_vcc_value),   512'(exp_vcc));
        check_ctrl(tag, valid, idx, last);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wf(input logic [31:0] base_a, input logic [31:0] base_b,
                            input logic [63:0] exec_v, input logic [63:0] vcc_v);
        src_a_data     = mk_vec(base_a);
        src_b_data     = mk_vec(base_b);
        src_exec_value = exec_v;
        src_vcc_value  = vcc_v;
    endtask

    initial begin
        rst                 = 1'b0;
        src_buffer_ld_en    = 1'b1;
        src_buffer_shift_en = 1'b1;
        drive_wf(32'h0000_0000, 32'h0000_0100, 64'hFFFF_0000_FFFF_0F0F, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset with load and shift asserted: load must not be taken.
        tick();
        tick();
        check("rst_a",    alu_src_a_data,       {512{1'b0}});
        check("rst_b",    alu_src_b_data,       {512{1'b0}});
        check("rst_exec", 512'(alu_exec_value), 512'(16'h0000));
        check("rst_vcc",  512'(alu_vcc_value),  512'(16'h0000));
        check_ctrl("rst", 1'b0, 2'd0, 1'b0);

        // Wavefront 1: load then continuous shift.
        rst                 = 1'b1;
        src_buffer_ld_en    = 1'b1;
        src_buffer_shift_en = 1'b0;
        tick();
        check_beat("wf1_b0", 32'h0, 32'h100, 0, 16'h0F0F, 16'hFFFF, 1'b1, 2'd0, 1'b0);
        src_buffer_ld_en    = 1'b0;
        src_buffer_shift_en = 1'b1;
        tick();
        check_beat("wf1_b1", 32'h0, 32'h100, 1, 16'hFFFF, 16'hFFFF, 1'b1, 2'd1, 1'b0);
        tick();
        check_beat("wf1_b2", 32'h0, 32'h100, 2, 16'h0000, 16'hFFFF, 1'b1, 2'd2, 1'b0);
        tick();
        check_beat("wf1_b3", 32'h0, 32'h100, 3, 16'hFFFF, 16'hFFFF, 1'b1, 2'd3, 1'b1);
        tick();
        // IDLE keeps the last beat's data on the outputs.
        check_beat("wf1_end", 32'h0, 32'h100, 3, 16'hFFFF, 16'hFFFF, 1'b0, 2'd0, 1'b0);
        tick();
        check_ctrl("idle_shift", 1'b0, 2'd0, 1'b0);
        check("idle_shift_a", alu_src_a_data, mk_slice(32'h0, 3));

        // Wavefront 2: stall at beat 1 for five cycles.
        drive_wf(32'h0000_1000, 32'h0000_2000, 64'h1234_5678_9ABC_DEF0, 64'h0000_FFFF_0000_FFFF);
        src_buffer_ld_en    = 1'b1;
        src_buffer_shift_en = 1'b0;
        tick();
        check_beat("wf2_b0", 32'h1000, 32'h2000, 0, 16'hDEF0, 16'hFFFF, 1'b1, 2'd0, 1'b0);
        src_buffer_ld_en    = 1'b0;
        src_buffer_shift_en = 1'b1;
        tick();
        check_beat("wf2_b1", 32'h1000, 32'h2000, 1, 16'h9ABC, 16'h0000, 1'b1, 2'd1, 1'b0);
        src_buffer_shift_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_beat("wf2_stall", 32'h1000, 32'h2000, 1, 16'h9ABC, 16'h0000, 1'b1, 2'd1, 1'b0);
        end
        src_buffer_shift_en = 1'b1;
        tick();
        check_beat("wf2_b2", 32'h1000, 32'h2000, 2, 16'h5678, 16'hFFFF, 1'b1, 2'd2, 1'b0);
        tick();
        check_beat("wf2_b3", 32'h1000, 32'h2000, 3, 16'h1234, 16'h0000, 1'b1, 2'd3, 1'b1);

        // Back-to-back: load of wavefront 3 coincides with the last shift.
        drive_wf(32'h0000_3000, 32'h0000_4000, 64'hAAAA_5555_0000_C3C3, 64'h0F0F_F0F0_1111_2222);
        src_buffer_ld_en    = 1'b1;
        src_buffer_shift_en = 1'b1;
        tick();
        check_beat("wf3_b0", 32'h3000, 32'h4000, 0, 16'hC3C3, 16'h2222, 1'b1, 2'd0, 1'b0);
        src_buffer_ld_en = 1'b0;
        tick();
        check_beat("wf3_b1", 32'h3000, 32'h4000, 1, 16'h0000, 16'h1111, 1'b1, 2'd1, 1'b0);

        // Mid-operation reload at beat 1: old beats 2-3 are never shown.
        drive_wf(32'h0000_5000, 32'h0000_6000, 64'h8001_4002_2004_1008, 64'h0000_0000_0000_0001);
        src_buffer_ld_en    = 1'b1;
        src_buffer_shift_en = 1'b0;
        tick();
        check_beat("wf4_b0", 32'h5000, 32'h6000, 0, 16'h1008, 16'h0001, 1'b1, 2'd0, 1'b0);
        src_buffer_ld_en    = 1'b0;
        src_buffer_shift_en = 1'b1;
        tick();
        check_beat("wf4_b1", 32'h5000, 32'h6000, 1, 16'h2004, 16'h0000, 1'b1, 2'd1, 1'b0);
        tick();
        check_beat("wf4_b2", 32'h5000, 32'h6000, 2, 16'h4002, 16'h0000, 1'b1, 2'd2, 1'b0);

        // Reset at beat 2; later shifts produce no beat.
        rst = 1'b0;
        tick();
        check("mrst_a",    alu_src_a_data,       {512{1'b0}});
        check("mrst_exec", 512'(alu_exec_value), 512'(16'h0000));
        check_ctrl("mrst", 1'b0, 2'd0, 1'b0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_ctrl("post_rst_shift", 1'b0, 2'd0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/src_shift_reg_out.md
Name: src_shift_reg_out

Overview:
- Source-side counterpart of the ALU destination collector.
- Captures one full 64-lane wavefront operand set (two 32-bit VGPR operands, exec mask, VCC) in a single load.
- Presents it to a 16-lane ALU datapath as four consecutive 16-lane beats, lanes 0-15 first.
- Beat order and count match the destination collector, so results re-assemble into the same lane positions.

Parameters:
- DATA_W, 32, bits per lane per operand.
- LANES, 64, lanes per wavefront.
- BEAT_LANES, 16, lanes per ALU beat; LANES/BEAT_LANES must equal 4.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low (0 = reset).
- src_a_data  input  2048  operand A, lane i at bits [32i+31:32i].
- src_b_data  input  2048  operand B, same packing.
- src_exec_value  input  64  exec mask, bit i = lane i.
- src_vcc_value  input  64  VCC, bit i = lane i.
- src_buffer_ld_en  input  1  capture all source inputs this cycle.
- src_buffer_shift_en  input  1  consumer accepts the current beat.
- alu_src_a_data  output  512  operand A for the current beat's 16 lanes.
- alu_src_b_data  output  512  operand B for the current beat's 16 lanes.
- alu_exec_value  output  16  exec slice for the current beat.
- alu_vcc_value  output  16  VCC slice for the current beat.
- beat_valid  output  1  current beat is valid.
- beat_idx  output  2  current beat number, 0..3.
- beat_last  output  1  beat_valid && beat_idx==3.
- busy  output  1  beats still pending; equals beat_valid.

Behaviour:
- Reset (rst==0 at a clk edge): all storage, data outputs, beat_valid, beat_idx, beat_last and busy go to 0. Reset overrides load and shift in that cycle.
- States: IDLE (beat_valid=0) and ISSUE (beat_valid=1, beat_idx counts 0..3).
- Load: src_buffer_ld_en=1 at edge T captures all four inputs. At T+1: beat_valid=1, beat_idx=0, outputs carry lanes 0-15 (bits [511:0] of A/B, bits [15:0] of exec/VCC). Latency is one cycle.
- Shift: in ISSUE with src_buffer_shift_en=1 at an edge:
  - beat_idx<3: beat_idx increments and outputs move to the next 16-lane group (beat k shows lanes 16k..16k+15).
  - beat_idx==3: go to IDLE; beat_valid=0, beat_idx=0.
- Hold: in ISSUE with shift_en=0, outputs and beat_idx stay unchanged indefinitely.
- Shift in IDLE is ignored; no state change.
- Load during ISSUE at any beat, including together with a shift: load wins. New data is captured and the next cycle shows beat 0 of the new wavefront. Back-to-back wavefronts therefore need no bubble when load and shift coincide on the last beat.
- Fixed cadence: beats are issued regardless of exec content. An all-zero exec slice still produces a beat, so latency stays aligned with the destination collector.
- Output data in IDLE: equal to the last held values. Consumers must qualify with beat_valid.
- Implementation: lane select may be a 4:1 mux indexed by beat_idx or a right-shift of the stored vectors by 512 bits per beat. Both must give identical output.

Decomposition:
- Shared ALU package holds: DATA_W, LANES, BEAT_LANES, BEATS=4, and a beat-index typedef of 2 bits.
- Sub-module shift_in_slice, parameterized by per-lane width W: stores LANES×W bits on load and outputs BEAT_LANES×W bits selected by beat_idx.
- Instantiate shift_in_slice four times: A and B with W=32, exec and VCC with W=1.
- Top level holds only the beat counter/FSM.

Test Plan:
- Reset: rst=0 for 2 cycles with ld_en=1 and shift_en=1 -> all outputs 0, beat_valid=0; the load is not taken.
- Single wavefront:
  - Stimulus: lane i of A = i, lane i of B = 0x100+i, exec=0xFFFF_0000_FFFF_0F0F, VCC=all 1s; load, then shift_en=1 continuously.
  - Required response, beats 0..3: alu_src_a lane0 = 0,16,32,48; exec slices = 0x0F0F, 0xFFFF, 0x0000, 0xFFFF; beat_last only on beat 3; beat_valid=0 the cycle after.
- Stall: shift_en held 0 for 5 cycles at beat 1 -> beat_idx=1 and data lanes 16-31 held stable; resumes at beat 2 when shift_en rises.
- Back-to-back: second load together with shift at beat 3 -> next cycle beat_idx=0 with the new wavefront's lanes 0-15; no gap in beat_valid.
- Mid-operation reload: load at beat 1 -> next cycle beat 0 of the new data; the old wavefront's beats 2-3 are never presented.
- Reset mid-operation: rst=0 at beat 2 -> beat_valid=0 and beat_idx=0 next cycle; a later shift_en=1 produces no beat.
